// File: rtl/lsu_dbus_master.sv
// Load/store data-bus initiator: lane alignment, misalignment rejection,
// ack/store-busy completion with timeout, and load-data extension.
module lsu_dbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_w_en_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_w_data_o,
  output logic [3:0]  dbus_sel_byte_o,
  input  logic [31:0] dbus_r_data_i,
  input  logic        dbus_ack_i,
  input  logic        store_busy_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    off;
  logic          is_b, is_h, is_w;
  logic          misaligned;
  logic          accept;
  logic [3:0]    sel_d;
  logic [31:0]   wdata_d;
  logic          b_q, h_q, uns_q;
  logic [CW-1:0] cnt_q;
  logic          seen_busy_q;
  logic          done_ok;
  logic          timeout;
  logic [31:0]   sh;
  logic [31:0]   ext;

  assign off = lsu_addr_i[1:0];

  // Unsupported encodings fall through to word access.
  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (lsu_funct3_i)
      3'b000, 3'b100: is_b = 1'b1;
      3'b001, 3'b101: is_h = 1'b1;
      default:        is_w = 1'b1;
    endcase
  end

  assign misaligned = (is_h & off[0]) | (is_w & (off != 2'b00));
  assign accept = (state_q == IDLE) & lsu_req_i & ~misaligned;

  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = lsu_wdata_i;
    unique case (1'b1)
      is_b: begin
        sel_d   = 4'b0001 << off;
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      is_h: begin
        sel_d   = 4'b0011 << off;
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = dbus_r_data_i >> {dbus_addr_o[1:0], 3'b000};

  always_comb begin
    ext = dbus_r_data_i;
    if (b_q)
      ext = {{24{sh[7] & ~uns_q}}, sh[7:0]};
    else if (h_q)
      ext = {{16{sh[15] & ~uns_q}}, sh[15:0]};
  end

  // A store may finish on ack, or on the falling edge of an observed busy.
  assign done_ok = dbus_w_en_o
                 ? (dbus_ack_i | (seen_busy_q & ~store_busy_i))
                 : dbus_ack_i;
  assign timeout = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (done_ok | timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbus_req_o  = (state_q == REQ);
  assign lsu_done_o  = (state_q == RESP);
  assign lsu_stall_o = accept | (state_q == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      seen_busy_q     <= 1'b0;
      b_q             <= 1'b0;
      h_q             <= 1'b0;
      uns_q           <= 1'b0;
      dbus_w_en_o     <= 1'b0;
      dbus_addr_o     <= '0;
      dbus_w_data_o   <= '0;
      dbus_sel_byte_o <= '0;
      lsu_rdata_o     <= '0;
      misalign_o      <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_o <= (state_q == IDLE) & lsu_req_i & misaligned;
      bus_err_o  <= (state_q == REQ) & timeout & ~done_ok;
      if (accept) begin
        cnt_q           <= '0;
        seen_busy_q     <= 1'b0;
        b_q             <= is_b;
        h_q             <= is_h;
        uns_q           <= lsu_funct3_i[2];
        dbus_w_en_o     <= lsu_we_i;
        dbus_addr_o     <= lsu_addr_i;
        dbus_w_data_o   <= wdata_d;
        dbus_sel_byte_o <= sel_d;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + CW'(1);
        if (store_busy_i) seen_busy_q <= 1'b1;
        if (state_d == RESP)
          lsu_rdata_o <= (~dbus_w_en_o & dbus_ack_i) ? ext : 32'h0;
      end
    end
  end

endmodule
